kiscv_control: RTL and testbench

- Multi-cycle control FSM for the KISC-V core.
- Decodes the latched instruction register and drives every datapath select flag.
- Acts as the single APB master for instruction fetch, load/store and the system trap sequence.
- Drives the PC, IR and register-file write strobes, so each instruction runs as a fixed sequence of states.

---
 rtl/kiscv_control.sv | 210 +++++++++++++++++++++
 tb/tb_kiscv_control.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/kiscv_control.sv
// rtl/kiscv_control.sv - KISC-V multi-cycle control FSM and APB master (KISCV_IRQ_EN adds the irq input)
module kiscv_control #(
  parameter logic [31:0] SYS_ADDR  = 32'h4,
  parameter bit          FENCE_NOP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        branch_cond,
  input  logic        pready,
`ifdef KISCV_IRQ_EN
  input  logic        irq,
`endif
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic        mem_access,
  output logic        sys_load,
  output logic        sys_load_pc,
  output logic        lui_flag,
  output logic        jal_flag,
  output logic        alu_flag,
  output logic        load_branch,
  output logic        load_jalr,
  output logic        load_pc,
  output logic        alu_rs1,
  output logic        alu_imm_i,
  output logic        immediate,
  output logic        ir_load,
  output logic        pc_load,
  output logic        pc_inc,
  output logic        reg_we,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_RST = 4'd0, S_FS = 4'd1, S_FA = 4'd2, S_EX = 4'd3,
    S_MS  = 4'd4, S_MA = 4'd5, S_WS = 4'd6, S_WA = 4'd7,
    S_RS  = 4'd8, S_RA = 4'd9, S_JP = 4'd10
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;

  state_t     st;
  logic [6:0] opcode;
  logic       op_load, op_store, op_mem, op_fence_nop, op_retire_ex;
  logic       irq_take;
  state_t     ex_next;
  logic       unused_ok;

  assign opcode       = instruction[6:0];
  assign op_load      = (opcode == OPC_LOAD);
  assign op_store     = (opcode == OPC_STORE);
  assign op_mem       = op_load | op_store;
  assign op_fence_nop = FENCE_NOP && (opcode == OPC_MISC);

  // Opcodes that finish entirely in EX; anything else non-memory traps.
  assign op_retire_ex = (opcode == OPC_OP) | (opcode == OPC_OP_IMM) |
                        (opcode == OPC_LUI) | (opcode == OPC_AUIPC) |
                        (opcode == OPC_JAL) | (opcode == OPC_JALR) |
                        (opcode == OPC_BRANCH) | op_fence_nop;

`ifdef KISCV_IRQ_EN
  assign irq_take = irq & ~op_mem;
`else
  assign irq_take = 1'b0;
`endif

  always_comb begin
    ex_next = S_FS;
    if (op_mem)
      ex_next = S_MS;
    else if (!op_retire_ex || irq_take)
      ex_next = S_WS;
  end

  // The system address lives in the datapath; upper IR bits are decoded there.
  assign unused_ok = ^{instruction[31:7], SYS_ADDR};
  assign state     = st;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= S_RST;
    end else begin
      case (st)
        S_RST:   st <= S_FS;
        S_FS:    st <= S_FA;
        S_FA:    if (pready) st <= S_EX;
        S_EX:    st <= ex_next;
        S_MS:    st <= S_MA;
        S_MA:    if (pready) st <= S_FS;
        S_WS:    st <= S_WA;
        S_WA:    if (pready) st <= S_RS;
        S_RS:    st <= S_RA;
        S_RA:    if (pready) st <= S_JP;
        S_JP:    st <= S_FS;
        default: st <= S_RST;
      endcase
    end
  end

  always_comb begin
    psel        = 1'b0;
    penable     = 1'b0;
    pwrite      = 1'b0;
    mem_access  = 1'b0;
    sys_load    = 1'b0;
    sys_load_pc = 1'b0;
    lui_flag    = 1'b0;
    jal_flag    = 1'b0;
    alu_flag    = 1'b0;
    load_branch = 1'b0;
    load_jalr   = 1'b0;
    load_pc     = 1'b0;
    alu_rs1     = 1'b0;
    alu_imm_i   = 1'b0;
    immediate   = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    reg_we      = 1'b0;
    case (st)
      S_FS: psel = 1'b1;
      S_FA: begin
        psel    = 1'b1;
        penable = 1'b1;
        ir_load = pready;
      end
      S_EX: begin
        case (opcode)
          OPC_OP: begin
            alu_flag = 1'b1;
            alu_rs1  = 1'b1;
            reg_we   = 1'b1;
            pc_inc   = 1'b1;
          end
          OPC_OP_IMM: begin
            alu_flag  = 1'b1;
            immediate = 1'b1;
            alu_imm_i = 1'b1;
            reg_we    = 1'b1;
            pc_inc    = 1'b1;
          end
          OPC_LUI, OPC_AUIPC: begin
            lui_flag = 1'b1;
            reg_we   = 1'b1;
            pc_inc   = 1'b1;
          end
          OPC_JAL: begin
            jal_flag = 1'b1;
            reg_we   = 1'b1;
            pc_load  = 1'b1;
          end
          OPC_JALR: begin
            load_jalr = 1'b1;
            load_pc   = 1'b1;
            alu_imm_i = 1'b1;
            reg_we    = 1'b1;
            pc_load   = 1'b1;
          end
          OPC_BRANCH: begin
            load_branch = 1'b1;
            alu_rs1     = 1'b1;
            pc_load     = branch_cond;
            pc_inc      = ~branch_cond;
          end
          default: pc_inc = op_fence_nop;
        endcase
      end
      S_MS, S_MA: begin
        psel       = 1'b1;
        mem_access = 1'b1;
        alu_imm_i  = op_load;
        pwrite     = op_store;
        if (st == S_MA) begin
          penable = 1'b1;
          reg_we  = pready & op_load;
          pc_inc  = pready;
        end
      end
      S_WS, S_WA: begin
        psel     = 1'b1;
        sys_load = 1'b1;
        pwrite   = 1'b1;
        penable  = (st == S_WA);
      end
      S_RS, S_RA: begin
        psel     = 1'b1;
        sys_load = 1'b1;
        penable  = (st == S_RA);
        ir_load  = (st == S_RA) & pready;
      end
      S_JP: begin
        sys_load_pc = 1'b1;
        pc_load     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_kiscv_control.sv
// tb/tb_kiscv_control.sv - self-checking bench for kiscv_control against a transaction-level model
module tb_kiscv_control;

  localparam logic [18:0] M_PSEL  = 19'd1 << 18;
  localparam logic [18:0] M_PEN   = 19'd1 << 17;
  localparam logic [18:0] M_PWR   = 19'd1 << 16;
  localparam logic [18:0] M_MEM   = 19'd1 << 15;
  localparam logic [18:0] M_SYS   = 19'd1 << 14;
  localparam logic [18:0] M_SLPC  = 19'd1 << 13;
  localparam logic [18:0] M_LUI   = 19'd1 << 12;
  localparam logic [18:0] M_JAL   = 19'd1 << 11;
  localparam logic [18:0] M_ALU   = 19'd1 << 10;
  localparam logic [18:0] M_LBR   = 19'd1 << 9;
  localparam logic [18:0] M_LJALR = 19'd1 << 8;
  localparam logic [18:0] M_LPC   = 19'd1 << 7;
  localparam logic [18:0] M_RS1   = 19'd1 << 6;
  localparam logic [18:0] M_IMMI  = 19'd1 << 5;
  localparam logic [18:0] M_IMM   = 19'd1 << 4;
  localparam logic [18:0] M_IRLD  = 19'd1 << 3;
  localparam logic [18:0] M_PCLD  = 19'd1 << 2;
  localparam logic [18:0] M_PCINC = 19'd1 << 1;
  localparam logic [18:0] M_WE    = 19'd1 << 0;

  logic        clk = 1'b0;
  logic        rst_n, branch_cond, pready, irq;
  logic [31:0] instruction;
  logic psel, penable, pwrite, mem_access, sys_load, sys_load_pc, lui_flag, jal_flag;
  logic alu_flag, load_branch, load_jalr, load_pc, alu_rs1, alu_imm_i, immediate;
  logic ir_load, pc_load, pc_inc, reg_we;
  logic [3:0]  state_unused;
  logic [18:0] dut_out;

  typedef struct {
    bit          rstn;
    bit          rdy;
    bit          irq;
    bit          bc;
    logic [31:0] ir;
    logic [18:0] exp;
    string       tag;
  } step_t;

  step_t plan[$];
  int    checks_total  = 0;
  int    checks_passed = 0;
  int    cyc = 0;

  always #5 clk = ~clk;

  kiscv_control dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .branch_cond(branch_cond),
    .pready(pready),
`ifdef KISCV_IRQ_EN
    .irq(irq),
`endif
    .psel(psel), .penable(penable), .pwrite(pwrite), .mem_access(mem_access),
    .sys_load(sys_load), .sys_load_pc(sys_load_pc), .lui_flag(lui_flag),
    .jal_flag(jal_flag), .alu_flag(alu_flag), .load_branch(load_branch),
    .load_jalr(load_jalr), .load_pc(load_pc), .alu_rs1(alu_rs1),
    .alu_imm_i(alu_imm_i), .immediate(immediate), .ir_load(ir_load),
    .pc_load(pc_load), .pc_inc(pc_inc), .reg_we(reg_we), .state(state_unused)
  );

  assign dut_out = {psel, penable, pwrite, mem_access, sys_load, sys_load_pc, lui_flag,
                    jal_flag, alu_flag, load_branch, load_jalr, load_pc, alu_rs1,
                    alu_imm_i, immediate, ir_load, pc_load, pc_inc, reg_we};

  // What EX must drive for each instruction class; zero means "no EX work" (mem or trap).
  function automatic logic [18:0] ex_mask(input logic [31:0] ir, input bit bc);
    logic [6:0] op;
    op = ir[6:0];
    case (op)
      7'b0110011: return M_ALU | M_RS1 | M_WE | M_PCINC;
      7'b0010011: return M_ALU | M_IMM | M_IMMI | M_WE | M_PCINC;
      7'b0110111, 7'b0010111: return M_LUI | M_WE | M_PCINC;
      7'b1101111: return M_JAL | M_WE | M_PCLD;
      7'b1100111: return M_LJALR | M_LPC | M_IMMI | M_WE | M_PCLD;
      7'b1100011: return M_LBR | M_RS1 | (bc ? M_PCLD : M_PCINC);
      7'b0001111: return M_PCINC;
      default:    return '0;
    endcase
  endfunction

  task automatic push(input bit rstn, input bit rdy, input bit irq_v, input bit bc,
                      input logic [31:0] ir, input logic [18:0] exp, input string tag);
    step_t s;
    s.rstn = rstn; s.rdy = rdy; s.irq = irq_v; s.bc = bc;
    s.ir = ir; s.exp = exp; s.tag = tag;
    plan.push_back(s);
  endtask

  // One APB transfer: setup, waits, then the access with pready high.
  task automatic apb(input logic [18:0] flags, input logic [18:0] done, input int waits,
                     input bit irq_v, input bit bc, input logic [31:0] ir, input string tag);
    push(1, 0, irq_v, bc, ir, flags, tag);
    for (int i = 0; i < waits; i++) push(1, 0, irq_v, bc, ir, flags | M_PEN, tag);
    push(1, 1, irq_v, bc, ir, flags | M_PEN | done, tag);
  endtask

  task automatic add_instr(input logic [31:0] ir, input bit bc, input int fw, input int mw,
                           input bit irq_ex, input string tag);
    logic [18:0] ex, ms;
    bit ld, stv;
    ld  = (ir[6:0] == 7'b0000011);
    stv = (ir[6:0] == 7'b0100011);
    ex  = ex_mask(ir, bc);
    apb(M_PSEL, M_IRLD, fw, 0, bc, ir, {tag, "_fetch"});
    push(1, 0, irq_ex, bc, ir, ex, {tag, "_ex"});
    if (ld || stv) begin
      ms = M_PSEL | M_MEM | (ld ? M_IMMI : M_PWR);
      apb(ms, M_PCINC | (ld ? M_WE : '0), mw, irq_ex, bc, ir, {tag, "_mem"});
    end else if (ex == '0 || irq_ex) begin
      apb(M_PSEL | M_SYS | M_PWR, '0, mw, irq_ex, bc, ir, {tag, "_save"});
      apb(M_PSEL | M_SYS, M_IRLD, mw, irq_ex, bc, ir, {tag, "_vec"});
      push(1, 0, 0, bc, ir, M_SLPC | M_PCLD, {tag, "_jp"});
    end
  endtask

  task automatic pin(input string name, input int act, input int req);
    checks_total++;
    if (act == req) checks_passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  initial begin
    int n0;
    step_t s;
    rst_n = 1'b0; pready = 1'b1; irq = 1'b0; branch_cond = 1'b0; instruction = '0;
    @(posedge clk);

    for (int i = 0; i < 3; i++) push(0, 1, 0, 0, 32'h0, '0, "reset");
    push(1, 1, 0, 0, 32'h0, '0, "release");

    n0 = plan.size();
    add_instr(32'h00500093, 0, 0, 0, 0, "addi");
    pin("len_addi", plan.size() - n0, 3);
    pin("ex_addi_mask", int'(ex_mask(32'h00500093, 0)), 'h433);
    pin("ex_beq_taken_mask", int'(ex_mask(32'h00208463, 1)), 'h244);

    add_instr(32'h002081b3, 0, 1, 0, 0, "add");
    add_instr(32'h123450b7, 0, 0, 0, 0, "lui");
    add_instr(32'h00001097, 0, 0, 0, 0, "auipc");
    add_instr(32'h008000ef, 0, 0, 0, 0, "jal");
    add_instr(32'h000080e7, 0, 2, 0, 0, "jalr");

    n0 = plan.size();
    add_instr(32'h0000a103, 0, 0, 2, 0, "lw");
    pin("len_lw_2wait", plan.size() - n0, 7);

    add_instr(32'h0020a023, 0, 0, 1, 0, "sw");
    add_instr(32'h00208463, 1, 0, 0, 0, "beq_t");
    add_instr(32'h00208463, 0, 0, 0, 0, "beq_nt");
    add_instr(32'h0000000f, 0, 0, 0, 0, "fence");

    n0 = plan.size();
    add_instr(32'h00000073, 0, 0, 0, 0, "ecall");
    pin("len_ecall", plan.size() - n0, 8);
    add_instr(32'hffffffff, 0, 1, 1, 0, "illegal");

    // Reset while a load waits in its access phase: nothing may retire.
    apb(M_PSEL, M_IRLD, 0, 0, 0, 32'h0000a103, "mrst_fetch");
    push(1, 0, 0, 0, 32'h0000a103, '0, "mrst_ex");
    push(1, 0, 0, 0, 32'h0000a103, M_PSEL | M_MEM | M_IMMI, "mrst_ms");
    push(0, 0, 0, 0, 32'h0000a103, M_PSEL | M_MEM | M_IMMI | M_PEN, "mrst_ma");
    push(1, 1, 0, 0, 32'h0000a103, '0, "mrst_rst");
    add_instr(32'h00500093, 0, 0, 0, 0, "post_rst");

`ifdef KISCV_IRQ_EN
    add_instr(32'h002081b3, 0, 0, 1, 1, "irq_add");
    add_instr(32'h0020a023, 0, 0, 0, 1, "irq_sw");
    add_instr(32'h00500093, 0, 0, 0, 0, "after_irq_sw");
`endif

    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(negedge clk);
      rst_n = s.rstn; pready = s.rdy; irq = s.irq;
      branch_cond = s.bc; instruction = s.ir;
      #2;
      cyc++;
      checks_total++;
      if (dut_out === s.exp) checks_passed++;
      else $display("FAIL %s cycle %0d: outputs=%05h required=%05h", s.tag, cyc, dut_out, s.exp);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
